pong_match_ctrl: RTL and testbench
==================================

Name: pong_match_ctrl

Overview:
- Match sequencer for the ping-pong game. Gates ball motion, requests ball re-centring, keeps both players' scores and declares the winner.
- Sits between the wall/paddle edge-detect logic and the ball/paddle update datapath.
- Score outputs drive the HEX score digits directly.
- Game logic advances only on the game-tick enable.

Parameters:
- WIN_SCORE, 9, score that ends the match; legal range 1..15.
- SERVE_DELAY, 50, ticks the ball is held at centre before release.
- POINT_DELAY, 25, ticks the ball is frozen after a point.
- RALLY_STEP, 4, paddle hits per speed level. Used only with RALLY_SPEEDUP_EN.

Ports:
- clk  in  1  system clock; one clock domain only.
- reset  in  1  synchronous, active-high reset.
- tick  in  1  one-clk-wide game-update enable pulse.
- start  in  1  start/restart request; sampled only on tick cycles.
- miss_left  in  1  ball touched left wall; player 2 scores.
- miss_right  in  1  ball touched right wall; player 1 scores.
- hit_left  in  1  ball/left-paddle collision.
- hit_right  in  1  ball/right-paddle collision.
- ball_run  out  1  ball datapath may integrate velocity.
- ball_load  out  1  one-clk pulse: reload ball to serve position.
- serve_dir  out  1  0 = serve toward left, 1 = toward right.
- score_one  out  4  player 1 score.
- score_two  out  4  player 2 score.
- game_over  out  1  match finished.
- winner  out  1  0 = player 1, 1 = player 2; valid while game_over=1.
- speed_lvl  out  2  ball speed level for the velocity datapath.
- state  out  3  current state, for debug/LED.

Behaviour:
- All outputs are registered. Inputs are sampled only on clk edges where tick=1; on other cycles state, counters and scores hold.
- Reset, with priority over everything: state=IDLE; all outputs 0; internal delay counter and rally counter 0. Reset asserted mid-match returns to IDLE on the next edge.
- State encoding: IDLE=0, SERVE=1, PLAY=2, POINT=3, GAME_OVER=4. Codes 5..7 go to IDLE on the next clk.
- IDLE: ball_run=0. On tick & start:
  - go to SERVE;
  - clear both scores;
  - serve_dir=0;
  - load delay counter with SERVE_DELAY;
  - pulse ball_load.
- SERVE: ball_run=0. On each tick, if counter==0 go to PLAY (ball_run=1 from the next cycle); otherwise decrement. SERVE therefore lasts SERVE_DELAY+1 ticks.
- PLAY: ball_run=1. On a tick, in priority order:
  - miss_left & miss_right together: ignored, stay in PLAY.
  - miss_left only: score_two+1; serve_dir=1.
  - miss_right only: score_one+1; serve_dir=0.
  - After a miss, if the new score == WIN_SCORE: go to GAME_OVER; winner = scoring player; game_over=1.
  - After a miss below WIN_SCORE: go to POINT with counter=POINT_DELAY; ball_run=0 from the next cycle.
  - Hits on the same tick as a miss are discarded.
  - Otherwise hit_left | hit_right increments the rally counter by exactly 1 per tick, even if both are set. The rally counter is 8-bit and saturates at 255.
- POINT: ball_run=0. Counts down the same way as SERVE. At 0:
  - go to SERVE with counter=SERVE_DELAY;
  - pulse ball_load;
  - clear the rally counter.
- GAME_OVER: ball_run=0, game_over=1; scores and winner hold. On tick & start:
  - go to SERVE;
  - scores cleared, game_over=0, winner=0;
  - pulse ball_load.
- start is ignored in SERVE, PLAY and POINT.
- ball_load is high for exactly one clk, on the cycle after the transitioning tick edge; it is never high on two consecutive clks.
- Latency: any output change is visible one clk after the tick edge that causes it.
- Scores never exceed WIN_SCORE, so there is no wrap.

Optional Feature:
- Macro: RALLY_SPEEDUP_EN.
- Defined:
  - speed_lvl increments each time the rally counter reaches a nonzero multiple of RALLY_STEP, saturating at 3.
  - speed_lvl clears to 0 together with every ball_load pulse and on reset.
- Undefined:
  - speed_lvl is tied to 0;
  - the rally counter logic is not synthesised.

Test Plan:
- Reset then idle: reset=1 for 2 clks, tick every 4 clks, start=0 → state=0, ball_run=0, scores 0/0, ball_load never pulses.
- Serve timing: SERVE_DELAY=3, start on a tick → ball_load high exactly 1 clk; state=1 for 4 ticks; ball_run=1 from the clk after the 4th tick.
- Point flow: in PLAY, miss_right on a tick → score_one=1, serve_dir=0, state=3. After POINT_DELAY+1 ticks, state=1 and one ball_load pulse.
- Simultaneous and priority: miss_left & miss_right on one tick → scores unchanged, stays PLAY. miss_left + hit_right on one tick → score_two+1, rally counter unchanged.
- Match end: WIN_SCORE=2, two miss_left ticks → score_two=2, game_over=1, winner=1, ball_run=0. start on a tick → scores 0/0, game_over=0, state=1.
- Speed-up (RALLY_SPEEDUP_EN, RALLY_STEP=2): 7 hit ticks → speed_lvl 0→1→2→3 and holds at 3; next ball_load returns speed_lvl to 0. Without the macro, speed_lvl stays 0.

Source files
------------

// File: rtl/pong_match_ctrl.sv
// Match sequencer for the ping-pong game: serve/point timing, scores, winner.
// Optional rally speed-up is enabled by defining RALLY_SPEEDUP_EN.
module pong_match_ctrl #(
  parameter int WIN_SCORE   = 9,
  parameter int SERVE_DELAY = 50,
  parameter int POINT_DELAY = 25,
  parameter int RALLY_STEP  = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       start,
  input  logic       miss_left,
  input  logic       miss_right,
  input  logic       hit_left,
  input  logic       hit_right,
  output logic       ball_run,
  output logic       ball_load,
  output logic       serve_dir,
  output logic [3:0] score_one,
  output logic [3:0] score_two,
  output logic       game_over,
  output logic       winner,
  output logic [1:0] speed_lvl,
  output logic [2:0] state
);

  localparam int DMAX  = (SERVE_DELAY > POINT_DELAY) ? SERVE_DELAY : POINT_DELAY;
  localparam int CNT_W = (DMAX < 1) ? 1 : $clog2(DMAX + 1);
  localparam logic [CNT_W-1:0] SERVE_CNT = CNT_W'(SERVE_DELAY);
  localparam logic [CNT_W-1:0] POINT_CNT = CNT_W'(POINT_DELAY);
  localparam logic [3:0]       WIN4      = 4'(WIN_SCORE);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SERVE     = 3'd1,
    PLAY      = 3'd2,
    POINT     = 3'd3,
    GAME_OVER = 3'd4
  } state_t;

  state_t           st_q, st_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       s1_d, s2_d;
  logic             dir_d, win_d, load_d;

  always_comb begin
    st_d   = st_q;
    cnt_d  = cnt_q;
    s1_d   = score_one;
    s2_d   = score_two;
    dir_d  = serve_dir;
    win_d  = winner;
    load_d = 1'b0;
    case (st_q)
      IDLE, GAME_OVER: begin
        if (tick && start) begin
          st_d   = SERVE;
          s1_d   = 4'd0;
          s2_d   = 4'd0;
          dir_d  = 1'b0;
          win_d  = 1'b0;
          cnt_d  = SERVE_CNT;
          load_d = 1'b1;
        end
      end
      SERVE: begin
        if (tick) begin
          if (cnt_q == '0) st_d = PLAY;
          else             cnt_d = cnt_q - 1'b1;
        end
      end
      PLAY: begin
        // A double miss is treated as a glitch and ignored entirely.
        if (tick && (miss_left != miss_right)) begin
          if (miss_left) begin
            s2_d  = score_two + 4'd1;
            dir_d = 1'b1;
          end else begin
            s1_d  = score_one + 4'd1;
            dir_d = 1'b0;
          end
          if ((s1_d == WIN4) || (s2_d == WIN4)) begin
            st_d  = GAME_OVER;
            win_d = miss_left;
          end else begin
            st_d  = POINT;
            cnt_d = POINT_CNT;
          end
        end
      end
      POINT: begin
        if (tick) begin
          if (cnt_q == '0) begin
            st_d   = SERVE;
            cnt_d  = SERVE_CNT;
            load_d = 1'b1;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q      <= IDLE;
      cnt_q     <= '0;
      score_one <= 4'd0;
      score_two <= 4'd0;
      serve_dir <= 1'b0;
      winner    <= 1'b0;
      ball_load <= 1'b0;
      ball_run  <= 1'b0;
      game_over <= 1'b0;
    end else begin
      st_q      <= st_d;
      cnt_q     <= cnt_d;
      score_one <= s1_d;
      score_two <= s2_d;
      serve_dir <= dir_d;
      winner    <= win_d;
      ball_load <= load_d;
      ball_run  <= (st_d == PLAY);
      game_over <= (st_d == GAME_OVER);
    end
  end

  assign state = st_q;

`ifdef RALLY_SPEEDUP_EN
  logic [7:0] rally_q;
  logic [7:0] rally_nxt;
  logic [1:0] spd_q;
  logic       rally_inc;
  logic       step_hit;

  // One count per tick even when both paddles report a hit.
  assign rally_inc = tick && (st_q == PLAY) && !miss_left && !miss_right &&
                     (hit_left || hit_right);
  assign rally_nxt = rally_q + 8'd1;
  assign step_hit  = ((int'(rally_nxt) % RALLY_STEP) == 0);

  always_ff @(posedge clk) begin
    if (reset || load_d) begin
      rally_q <= 8'd0;
      spd_q   <= 2'd0;
    end else if (rally_inc && (rally_q != 8'hFF)) begin
      rally_q <= rally_nxt;
      if (step_hit && (spd_q != 2'd3)) spd_q <= spd_q + 2'd1;
    end
  end

  assign speed_lvl = spd_q;
`else
  localparam int unused_rally_step = RALLY_STEP;
  logic unused_hits;
  assign unused_hits = hit_left ^ hit_right;
  assign speed_lvl   = 2'd0;
`endif

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Self-checking bench for pong_match_ctrl: vector table fed through a scoreboard,
// hold checks between ticks, plus hand-written reset sequences.
module tb_pong_match_ctrl;

  logic       clk, reset, tick, start;
  logic       miss_left, miss_right, hit_left, hit_right;
  logic       ball_run, ball_load, serve_dir, game_over, winner;
  logic [3:0] score_one, score_two;
  logic [1:0] speed_lvl;
  logic [2:0] state;

  localparam bit SPEED_EN =
`ifdef RALLY_SPEEDUP_EN
    1'b1;
`else
    1'b0;
`endif

  pong_match_ctrl #(
    .WIN_SCORE(2), .SERVE_DELAY(3), .POINT_DELAY(2), .RALLY_STEP(2)
  ) dut (
    .clk(clk), .reset(reset), .tick(tick), .start(start),
    .miss_left(miss_left), .miss_right(miss_right),
    .hit_left(hit_left), .hit_right(hit_right),
    .ball_run(ball_run), .ball_load(ball_load), .serve_dir(serve_dir),
    .score_one(score_one), .score_two(score_two),
    .game_over(game_over), .winner(winner),
    .speed_lvl(speed_lvl), .state(state)
  );

  typedef struct {
    logic [4:0] in;   // {start, miss_left, miss_right, hit_left, hit_right}
    logic [2:0] st;
    logic       run, load, dir, dcare;
    logic [3:0] s1, s2;
    logic       go, w;
    logic [1:0] spd;
  } vec_t;

  vec_t tbl[$];
  vec_t sb_q[$];
  vec_t last_exp;
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   chk_en = 1'b0;
  logic tick_d = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [4:0] in, input logic [2:0] st,
                              input logic run, input logic load, input logic dir,
                              input logic [3:0] s1, input logic [3:0] s2,
                              input logic go, input logic w, input logic [1:0] spd);
    vec_t v;
    v.in = in; v.st = st; v.run = run; v.load = load; v.dir = dir; v.dcare = 1'b1;
    v.s1 = s1; v.s2 = s2; v.go = go; v.w = w;
    v.spd = SPEED_EN ? spd : 2'd0;
    return v;
  endfunction

  function automatic vec_t nodir(input vec_t v);
    vec_t r = v;
    r.dcare = 1'b0;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
    end
  endtask

  task automatic cmp_rec(input string tag, input vec_t e, input logic exp_load);
    chk({tag, ".state"},     state,     e.st);
    chk({tag, ".ball_run"},  ball_run,  e.run);
    chk({tag, ".ball_load"}, ball_load, exp_load);
    if (e.dcare) chk({tag, ".serve_dir"}, serve_dir, e.dir);
    chk({tag, ".score_one"}, score_one, e.s1);
    chk({tag, ".score_two"}, score_two, e.s2);
    chk({tag, ".game_over"}, game_over, e.go);
    chk({tag, ".winner"},    winner,    e.w);
    chk({tag, ".speed_lvl"}, speed_lvl, e.spd);
  endtask

  task automatic chk_zero(input string tag);
    vec_t z = mk(5'b00000, 3'd0, 0, 0, 0, 4'd0, 4'd0, 0, 0, 2'd0);
    chk({tag, ".serve_dir"}, serve_dir, 1'b0);
    cmp_rec(tag, z, 1'b0);
  endtask

  always @(posedge clk) tick_d <= tick;

  // Outputs are sampled on the falling edge, half a cycle after the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      if (tick_d) begin
        if (sb_q.size() == 0) begin
          chk("sb_underflow", 32'd1, 32'd0);
        end else begin
          last_exp = sb_q.pop_front();
          cmp_rec("tick", last_exp, last_exp.load);
        end
      end else begin
        cmp_rec("hold", last_exp, 1'b0);
      end
    end
  end

  task automatic apply(input vec_t v);
    @(posedge clk); #2;
    {start, miss_left, miss_right, hit_left, hit_right} = v.in;
    tick = 1'b1;
    sb_q.push_back(v);
    @(posedge clk); #2;
    tick = 1'b0;
    {start, miss_left, miss_right, hit_left, hit_right} = 5'b00000;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; tick = 1'b0;
    {start, miss_left, miss_right, hit_left, hit_right} = 5'b00000;

    // IDLE, serve, first rally and a point to player 1
    tbl.push_back(mk(5'b00000, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(5'b00010, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(5'b10000, 1, 0, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(5'b00000, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(5'b10000, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(5'b00000, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(5'b00000, 2, 1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(5'b00010, 2, 1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(5'b00001, 2, 1, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(5'b00011, 2, 1, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(5'b10010, 2, 1, 0, 0, 0, 0, 0, 0, 2));
    tbl.push_back(mk(5'b00001, 2, 1, 0, 0, 0, 0, 0, 0, 2));
    tbl.push_back(mk(5'b01100, 2, 1, 0, 0, 0, 0, 0, 0, 2));
    tbl.push_back(mk(5'b00110, 3, 0, 0, 0, 1, 0, 0, 0, 2));
    tbl.push_back(mk(5'b10000, 3, 0, 0, 0, 1, 0, 0, 0, 2));
    tbl.push_back(mk(5'b00000, 3, 0, 0, 0, 1, 0, 0, 0, 2));
    tbl.push_back(mk(5'b00000, 1, 0, 1, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(5'b00000, 1, 0, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(5'b00000, 1, 0, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(5'b00000, 1, 0, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(5'b00000, 2, 1, 0, 0, 1, 0, 0, 0, 0));
    // seven hit ticks: speed climbs to 3 and saturates
    tbl.push_back(mk(5'b00010, 2, 1, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(5'b00001, 2, 1, 0, 0, 1, 0, 0, 0, 1));
    tbl.push_back(mk(5'b00010, 2, 1, 0, 0, 1, 0, 0, 0, 1));
    tbl.push_back(mk(5'b00011, 2, 1, 0, 0, 1, 0, 0, 0, 2));
    tbl.push_back(mk(5'b00001, 2, 1, 0, 0, 1, 0, 0, 0, 2));
    tbl.push_back(mk(5'b00010, 2, 1, 0, 0, 1, 0, 0, 0, 3));
    tbl.push_back(mk(5'b00001, 2, 1, 0, 0, 1, 0, 0, 0, 3));
    // point to player 2, re-serve toward the right
    tbl.push_back(mk(5'b01000, 3, 0, 0, 1, 1, 1, 0, 0, 3));
    tbl.push_back(mk(5'b00000, 3, 0, 0, 1, 1, 1, 0, 0, 3));
    tbl.push_back(mk(5'b00000, 3, 0, 0, 1, 1, 1, 0, 0, 3));
    tbl.push_back(mk(5'b00000, 1, 0, 1, 1, 1, 1, 0, 0, 0));
    tbl.push_back(mk(5'b00000, 1, 0, 0, 1, 1, 1, 0, 0, 0));
    tbl.push_back(mk(5'b00000, 1, 0, 0, 1, 1, 1, 0, 0, 0));
    tbl.push_back(mk(5'b00000, 1, 0, 0, 1, 1, 1, 0, 0, 0));
    tbl.push_back(mk(5'b00000, 2, 1, 0, 1, 1, 1, 0, 0, 0));
    // winning miss with a same-tick hit, then restart from GAME_OVER
    tbl.push_back(mk(5'b01001, 4, 0, 0, 1, 1, 2, 1, 1, 0));
    tbl.push_back(mk(5'b00010, 4, 0, 0, 1, 1, 2, 1, 1, 0));
    tbl.push_back(nodir(mk(5'b10000, 1, 0, 1, 0, 0, 0, 0, 0, 0)));
    tbl.push_back(nodir(mk(5'b00000, 1, 0, 0, 0, 0, 0, 0, 0, 0)));
    tbl.push_back(nodir(mk(5'b00000, 1, 0, 0, 0, 0, 0, 0, 0, 0)));
    tbl.push_back(nodir(mk(5'b00000, 1, 0, 0, 0, 0, 0, 0, 0, 0)));
    tbl.push_back(nodir(mk(5'b00000, 2, 1, 0, 0, 0, 0, 0, 0, 0)));
    tbl.push_back(mk(5'b00100, 3, 0, 0, 0, 1, 0, 0, 0, 0));

    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    reset = 1'b0;
    last_exp = mk(5'b00000, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk_en = 1'b1;

    // idle with no start: nothing moves across several clocks
    repeat (4) @(posedge clk);

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

    // reset mid-match (in POINT with a nonzero score)
    @(posedge clk); #2;
    chk_en = 1'b0;
    reset  = 1'b1;
    @(posedge clk); #1;
    chk_zero("midreset");
    reset = 1'b0;
    last_exp = mk(5'b00000, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk_en = 1'b1;

    apply(mk(5'b10000, 1, 0, 1, 0, 0, 0, 0, 0, 0));
    apply(mk(5'b00000, 1, 0, 0, 0, 0, 0, 0, 0, 0));

    repeat (3) @(posedge clk);
    chk("sb_drain", sb_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
